// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch block: FSM states, widths and the
// buffered fetch entry.
package fetch_pkg;

   localparam int unsigned ADDR_W  = 16;
   localparam int unsigned INSTR_W = 16;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      DROP
   } fetch_state_e;

   typedef struct packed {
      logic [INSTR_W-1:0] instr;
      logic [ADDR_W-1:0]  pc;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small instruction buffer with synchronous flush; the head entry is shown
// directly from storage and reads as zero when the buffer is empty.
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int unsigned DEPTH = 2
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   i_flush,
   input  logic                   i_push,
   input  fetch_entry_t           i_data,
   input  logic                   i_pop,
   output fetch_entry_t           o_head,
   output logic [$clog2(DEPTH):0] o_count
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   fetch_entry_t     r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;
   logic             w_push;
   logic             w_pop;

   // Flush dominates both push and pop; popping an empty buffer is a no-op.
   assign w_push = i_push && !i_flush;
   assign w_pop  = i_pop && !i_flush && (r_count != '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         if (w_push && !w_pop)      r_count <= r_count + CNT_W'(1);
         else if (w_pop && !w_push) r_count <= r_count - CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= i_data;
   end

   assign o_head  = (r_count != '0) ? r_mem[r_rd_ptr] : '0;
   assign o_count = r_count;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: PC next-value select, single-outstanding memory request
// FSM and decode handoff buffer. Define FETCH_PERF_EN to add stall_cycles.
module instr_fetch
   import fetch_pkg::*;
#(
   parameter logic [ADDR_W-1:0] RESET_PC   = 16'h0000,
   parameter int unsigned       FIFO_DEPTH = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [ADDR_W-1:0]  instruction_address,
   output logic [ADDR_W-1:0]  next_instruction_address,
   input  logic               redirect_valid,
   input  logic [ADDR_W-1:0]  redirect_target,
   output logic               imem_req,
   output logic [ADDR_W-1:0]  imem_addr,
   input  logic               imem_gnt,
   input  logic               imem_rvalid,
   input  logic [INSTR_W-1:0] imem_rdata,
   output logic               out_valid,
   output logic [INSTR_W-1:0] out_instr,
   output logic [ADDR_W-1:0]  out_pc,
   input  logic               out_ready
`ifdef FETCH_PERF_EN
   ,
   output logic [15:0]        stall_cycles
`endif
);

   localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

   fetch_state_e      r_state;
   fetch_state_e      w_state_nxt;
   logic [ADDR_W-1:0] r_issue_pc;
   logic [CNT_W-1:0]  w_count;
   logic              w_outstanding;
   logic              w_room;
   logic              w_accept;
   logic              w_push;
   logic              w_pop;
   fetch_entry_t      w_push_entry;
   fetch_entry_t      w_head;

   assign imem_addr     = instruction_address;
   assign w_outstanding = (r_state != IDLE);
   assign w_room        = (w_count + CNT_W'(w_outstanding)) < CNT_W'(FIFO_DEPTH);
   assign imem_req      = rst_n && (r_state == IDLE) && !redirect_valid && w_room;
   assign w_accept      = imem_req && imem_gnt;

   always_comb begin
      if (!rst_n)              next_instruction_address = RESET_PC;
      else if (redirect_valid) next_instruction_address = redirect_target;
      else if (w_accept)       next_instruction_address = instruction_address + ADDR_W'(1);
      else                     next_instruction_address = instruction_address;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_state_nxt;
   end

   // A response that coincides with a redirect is consumed and discarded, so
   // WAIT returns straight to IDLE instead of parking in DROP forever.
   always_comb begin
      w_state_nxt = r_state;
      w_push      = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_accept) w_state_nxt = WAIT;
         end
         WAIT: begin
            if (imem_rvalid) begin
               w_push      = !redirect_valid;
               w_state_nxt = IDLE;
            end else if (redirect_valid) begin
               w_state_nxt = DROP;
            end
         end
         DROP: begin
            if (imem_rvalid) w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)        r_issue_pc <= '0;
      else if (w_accept) r_issue_pc <= instruction_address;
   end

   assign w_push_entry = '{instr: imem_rdata, pc: r_issue_pc};
   assign w_pop        = out_valid && out_ready;

   fetch_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_flush (redirect_valid),
      .i_push  (w_push),
      .i_data  (w_push_entry),
      .i_pop   (w_pop),
      .o_head  (w_head),
      .o_count (w_count)
   );

   assign out_valid = (w_count != '0);
   assign out_instr = w_head.instr;
   assign out_pc    = w_head.pc;

`ifdef FETCH_PERF_EN
   logic [15:0] r_stall_cycles;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                  r_stall_cycles <= '0;
      else if (redirect_valid)     r_stall_cycles <= '0;
      else if (out_ready && !out_valid && (r_stall_cycles != '1))
                                   r_stall_cycles <= r_stall_cycles + 16'd1;
   end

   assign stall_cycles = r_stall_cycles;
`endif

endmodule
